dac_timed_sequencer: RTL
========================

DAC_TIMED_SEQUENCER -- requirements
Module: dac_timed_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of DDS channels (1..8).
REQ-002 SHALL have parameter FIFO_DEPTH, default 64, event FIFO entries (power of 2, >=4); FIFO_AW = log2(FIFO_DEPTH).
REQ-003 SHALL have port s_axi_aclk  in  1  sole clock; one clock, all logic on its rising edge.
REQ-004 SHALL have port s_axi_aresetn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports write in 1 event push strobe; fifo_din in 128 event word; flush in 1 discard all queued events and stop.
REQ-006 SHALL have ports auto_start in 1 start pulse; counter in 64 global time; err_clr in 1 clears sticky errors.
REQ-007 SHALL have ports full out 1; empty out 1; fill_level out FIFO_AW+1; running out 1.
REQ-008 SHALL have ports freq out NUM_CH*48; amp out NUM_CH*14; phase out NUM_CH*14; amp_offset out NUM_CH*14; dac_mode out NUM_CH (0 DDS, 1 direct); update out NUM_CH one-cycle strobe per applied event.
REQ-009 SHALL have ports timestamp_error, overflow_error, illegal_error out 1 each (sticky); error_data out 128 (first offending event).

Function
REQ-010 Event word SHALL be [127:64] timestamp, [63:60] opcode, [59:56] channel, [55:0] data.
REQ-011 Opcodes SHALL be 0 SET_FREQ (data[47:0]), 1 SET_AMP_PHASE (amp=data[27:14], phase=data[13:0]), 2 SET_OFFSET (amp_offset=data[13:0]), 3 SET_MODE (dac_mode=data[0]); 4..15 illegal.
REQ-012 write while not full SHALL enqueue fifo_din; write while full SHALL drop word, set overflow_error, capture error_data if no error yet latched.
REQ-013 write and pop in same cycle while full SHALL accept the write (count unchanged).
REQ-014 FIFO SHALL be first-word-fall-through; fill_level exact, updated the cycle after push/pop.
REQ-015 FSM states STOP, RUN; STOP->RUN on auto_start; RUN->STOP on flush; reset -> STOP; running=1 in RUN.
REQ-016 In STOP no event SHALL be popped; writes still accepted.
REQ-017 In RUN with head valid and head.timestamp == counter (unsigned): pop; channel/opcode legal -> target register and update[ch] asserted exactly 1 cycle later.
REQ-018 In RUN with head.timestamp < counter: pop, discard, set timestamp_error, capture error_data; no update.
REQ-019 Popped event with channel >= NUM_CH or illegal opcode SHALL be discarded, illegal_error set, error_data captured.
REQ-020 At most one pop per cycle; equal-timestamp successor SHALL therefore be reported late per REQ-018.
REQ-021 error_data SHALL hold the first error since last err_clr/reset; later errors only set flags.
REQ-022 err_clr SHALL clear all three flags and error_data next cycle; error in same cycle as err_clr SHALL win (flag set).
REQ-023 flush SHALL empty FIFO in one cycle (fill_level 0 next cycle); write in same cycle dropped without error; channel registers retained.
REQ-024 flush and auto_start simultaneous: flush wins, state STOP.
REQ-025 Counter wrap (0xFFFF_FFFF_FFFF_FFFF -> 0) SHALL need no special handling; comparison plain unsigned.

Reset
REQ-026 On s_axi_aresetn low: FIFO empty, fill_level 0, empty=1, full=0, state STOP, running 0.
REQ-027 On reset: freq, amp, phase, amp_offset, dac_mode, update, all error flags and error_data = 0.
REQ-028 Reset mid-operation SHALL discard queued and in-flight events; no update pulse after reset deassertion.

Structure
REQ-029 Package dac_seq_pkg SHALL hold opcode enum, event struct/field positions, width constants (48, 14, 64).
REQ-030 One sub-module rto_event_fifo (synchronous FWFT FIFO, parameter depth/width, flush, fill_level) SHALL be used.

Verification
REQ-031 Reset, push SET_FREQ ch1 data 0x123456789ABC ts=100, auto_start, counter 0..110 -> freq[ch1]=0x123456789ABC and update[1] at counter 101 cycle; others 0.
REQ-032 Push ts=50, start at counter 60 -> timestamp_error=1, error_data=event, no update; err_clr -> flags 0.
REQ-033 Push FIFO_DEPTH+1 events in STOP -> full=1, fill_level=64, overflow_error=1, error_data=65th word.
REQ-034 Two events ts=200 ch0 SET_MODE 1 and ts=200 ch2 SET_AMP_PHASE -> first applied (dac_mode[0]=1), second timestamp_error.
REQ-035 Event channel 7 with NUM_CH=4, and opcode 9 -> illegal_error=1, no outputs change.
REQ-036 Full FIFO, write+pop same cycle -> fill_level stays 64, no overflow; then flush+write -> fill_level 0, running 0, no error.

Source files
------------

// File: rtl/dac_seq_pkg.sv
// Shared types and widths for the timed DAC event sequencer.
// An event word is {timestamp, opcode, channel, data}, 128 bits in total.
package dac_seq_pkg;

  localparam int TS_W    = 64;
  localparam int FREQ_W  = 48;
  localparam int AMP_W   = 14;
  localparam int DATA_W  = 56;
  localparam int EVENT_W = 128;

  // Bit positions of the fields inside an event word
  localparam int EV_TS_LSB = 64;
  localparam int EV_OP_LSB = 60;
  localparam int EV_CH_LSB = 56;

  typedef enum logic [3:0] {
    OP_SET_FREQ      = 4'd0,
    OP_SET_AMP_PHASE = 4'd1,
    OP_SET_OFFSET    = 4'd2,
    OP_SET_MODE      = 4'd3
  } opcode_e;

  typedef struct packed {
    logic [TS_W-1:0]   timestamp;
    logic [3:0]        opcode;
    logic [3:0]        channel;
    logic [DATA_W-1:0] data;
  } event_t;

  typedef enum logic {
    ST_STOP = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  // Opcodes 4..15 are reserved.
  function automatic logic opcode_legal(input logic [3:0] op);
    return op <= OP_SET_MODE;
  endfunction

endpackage

// File: rtl/rto_event_fifo.sv
// Synchronous first-word-fall-through FIFO with a single-cycle flush.
// A write that arrives together with a pop is accepted even when the FIFO is full.
module rto_event_fifo #(
  parameter  int DEPTH = 64,
  parameter  int WIDTH = 128,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk_sys,
  input  logic             rst_b,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  input  logic             flush,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      fill_level
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full       = (count == FULL_CNT);
  assign empty      = (count == '0);
  assign fill_level = count;
  assign rd_data    = mem[rd_ptr];

  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);

  always_ff @(posedge clk_sys) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_b) begin
    if (!rst_b) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dac_timed_sequencer.sv
// Plays time-stamped DDS register events against a free-running global counter.
// Events whose timestamp has already passed, or that are malformed, raise sticky errors.
//
//   state | meaning
//   STOP  | events may be queued but none are popped
//   RUN   | head event popped when its timestamp <= counter
module dac_timed_sequencer
  import dac_seq_pkg::*;
#(
  parameter  int NUM_CH     = 4,
  parameter  int FIFO_DEPTH = 64,
  localparam int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                       s_axi_aclk,
  input  logic                       s_axi_aresetn,
  input  logic                       write,
  input  logic [EVENT_W-1:0]         fifo_din,
  input  logic                       flush,
  input  logic                       auto_start,
  input  logic [TS_W-1:0]            counter,
  input  logic                       err_clr,
  output logic                       full,
  output logic                       empty,
  output logic [FIFO_AW:0]           fill_level,
  output logic                       running,
  output logic [NUM_CH*FREQ_W-1:0]   freq,
  output logic [NUM_CH*AMP_W-1:0]    amp,
  output logic [NUM_CH*AMP_W-1:0]    phase,
  output logic [NUM_CH*AMP_W-1:0]    amp_offset,
  output logic [NUM_CH-1:0]          dac_mode,
  output logic [NUM_CH-1:0]          update,
  output logic                       timestamp_error,
  output logic                       overflow_error,
  output logic                       illegal_error,
  output logic [EVENT_W-1:0]         error_data
);

  localparam logic [3:0] CH_LIMIT = 4'(NUM_CH);

  seq_state_e state;
  seq_state_e state_nxt;
  event_t     head;
  logic       pop;
  logic       late;
  logic       bad;
  logic       apply;
  logic       ts_set;
  logic       ill_set;
  logic       ov_set;
  logic       err_hold;

  rto_event_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (EVENT_W)
  ) u_fifo (
    .clk_sys    (s_axi_aclk),
    .rst_b      (s_axi_aresetn),
    .push       (write),
    .wr_data    (fifo_din),
    .pop        (pop),
    .flush      (flush),
    .rd_data    (head),
    .full       (full),
    .empty      (empty),
    .fill_level (fill_level)
  );

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state <= ST_STOP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STOP: if (!flush && auto_start) state_nxt = ST_RUN;
      ST_RUN:  if (flush) state_nxt = ST_STOP;
      default: state_nxt = ST_STOP;
    endcase
  end

  always_comb begin
    running = (state == ST_RUN);
  end

  // A late or equal head is always consumed so one stale event cannot block the queue.
  assign late    = head.timestamp < counter;
  assign pop     = running && !flush && !empty && (head.timestamp <= counter);
  assign bad     = (head.channel >= CH_LIMIT) || !opcode_legal(head.opcode);
  assign apply   = pop && !late && !bad;
  assign ts_set  = pop && late;
  assign ill_set = pop && !late && bad;
  assign ov_set  = write && full && !pop && !flush;

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      freq       <= '0;
      amp        <= '0;
      phase      <= '0;
      amp_offset <= '0;
      dac_mode   <= '0;
      update     <= '0;
    end else begin
      update <= '0;
      if (apply) begin
        for (int i = 0; i < NUM_CH; i++) begin
          if (head.channel == 4'(i)) begin
            update[i] <= 1'b1;
            case (head.opcode)
              OP_SET_FREQ: freq[i*FREQ_W +: FREQ_W] <= head.data[FREQ_W-1:0];
              OP_SET_AMP_PHASE: begin
                amp[i*AMP_W +: AMP_W]   <= head.data[2*AMP_W-1:AMP_W];
                phase[i*AMP_W +: AMP_W] <= head.data[AMP_W-1:0];
              end
              OP_SET_OFFSET: amp_offset[i*AMP_W +: AMP_W] <= head.data[AMP_W-1:0];
              OP_SET_MODE:   dac_mode[i] <= head.data[0];
              default: ;
            endcase
          end
        end
      end
    end
  end

  // err_clr and a new error in the same cycle: the new error becomes the first one.
  assign err_hold = !err_clr && (timestamp_error || overflow_error || illegal_error);

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      timestamp_error <= 1'b0;
      overflow_error  <= 1'b0;
      illegal_error   <= 1'b0;
      error_data      <= '0;
    end else begin
      timestamp_error <= (timestamp_error && !err_clr) || ts_set;
      overflow_error  <= (overflow_error && !err_clr) || ov_set;
      illegal_error   <= (illegal_error && !err_clr) || ill_set;
      if (!err_hold && (ts_set || ill_set)) begin
        error_data <= head;
      end else if (!err_hold && ov_set) begin
        error_data <= fifo_din;
      end else if (err_clr) begin
        error_data <= '0;
      end
    end
  end

endmodule
